garuda_mac_arbiter: RTL
=======================

# garuda_mac_arbiter

Round-robin arbiter that shares one `int8_mac_unit` among `NUM_REQ` requesters (harts or accelerator lanes). It accepts operand bundles over per-requester valid/ready handshakes and issues at most one per cycle to the MAC unit. It bounds in-flight operations with a credit counter, tags each issue, and routes each MAC result back to its originating requester. A tag scoreboard flags protocol errors on the return path.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..4 (requester index carried on 2-bit `hartid`).
- `XLEN`, default 32: operand/result width.
- `MAX_OUTSTANDING`, default 2: maximum issued-but-unreturned operations, 1..8.
- `clk_i`  in  1  clock; all state on rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `req_valid_i`  in  NUM_REQ  per-requester request valid.
- `req_ready_o`  out  NUM_REQ  per-requester grant (one-hot or zero).
- `req_rs1_i`, `req_rs2_i`, `req_rd_i`  in  NUM_REQ*XLEN  packed operands, requester i at slice i.
- `req_opcode_i`  in  NUM_REQ*4  packed MAC opcodes (forwarded unchanged).
- `req_rd_addr_i`  in  NUM_REQ*5  packed destination register addresses.
- `mac_valid_o`  out  1  issue strobe to the MAC unit.
- `mac_rs1_o`, `mac_rs2_o`, `mac_rd_o`  out  XLEN  issued operands.
- `mac_opcode_o`  out  4  issued opcode.
- `mac_rd_addr_o`  out  5  issued destination address.
- `mac_hartid_o`  out  2  granted requester index.
- `mac_id_o`  out  3  transaction tag.
- `mac_valid_i`, `mac_we_i`  in  1  MAC result valid / write enable.
- `mac_result_i`  in  XLEN  MAC result.
- `mac_rd_addr_i`  in  5  MAC result address.
- `mac_hartid_i`  in  2  MAC result requester index.
- `mac_id_i`  in  3  MAC result tag.
- `rsp_valid_o`  out  NUM_REQ  one-hot response strobe.
- `rsp_we_o`  out  1  registered copy of `mac_we_i`.
- `rsp_result_o`  out  XLEN  registered result, shared by all requesters.
- `rsp_rd_addr_o`  out  5  registered result address, shared by all requesters.
- `err_o`  out  1  sticky protocol error.
- `perf_sel_i`  in  2  performance counter select.
- `perf_cnt_o`  out  32  selected grant count.

## Operation
- **Eligibility.** Grant is allowed when `outstanding < MAX_OUTSTANDING`. A response arriving in the same cycle does not add a credit.
- **Arbitration.** Among the asserted `req_valid_i`, grant the first index at or after the RR pointer, wrapping.
  - `req_ready_o[g]` is combinational and may depend on `req_valid_i`.
  - A handshake occurs when both `req_valid_i[g]` and `req_ready_o[g]` are high.
- **On handshake:**
  - Register requester g's operands, opcode and rd_addr onto the `mac_*_o` outputs.
  - Set `mac_hartid_o = g` and `mac_id_o` = current tag.
  - Increment the tag, 3-bit, wrapping 7 to 0.
  - Set RR pointer to (g+1) mod NUM_REQ.
  - Set scoreboard `busy[tag]` and record `owner[tag] = g`.
  - Increment `outstanding`.
- **On `mac_valid_i`:**
  - Decrement `outstanding`.
  - Clear `busy[mac_id_i]`.
  - Register result, we and rd_addr onto the `rsp_*` outputs.
  - Assert `rsp_valid_o[mac_hartid_i]` for 1 cycle.
- **Simultaneous issue and return:** `outstanding` is unchanged. The busy bits for different tags update independently.
- **Errors.** Set `err_o` and hold it until reset on any of:
  - `mac_valid_i` with `busy[mac_id_i] == 0`;
  - `owner[mac_id_i] != mac_hartid_i`;
  - `mac_hartid_i >= NUM_REQ`.
- **On error:** No `rsp_valid_o` is raised. Counters and busy bits are not modified.
- **Return path.** There is no backpressure; requesters must sink a response in the cycle `rsp_valid_o` is high.
- **Opcode.** Never inspected. ILLEGAL is forwarded and the MAC unit's behaviour applies.
- **Reset (any time):** Clears pointer, tag, outstanding, scoreboard and `err_o`.
  - The MAC unit must be reset together with the arbiter.
  - Stale returns after reset raise `err_o`.

## Timing
- Reset values:
  - all outputs 0;
  - `req_ready_o = 0`;
  - RR pointer 0, tag 0, outstanding 0.
- Latency:
  - issue: handshake in cycle N gives `mac_valid_o` in cycle N+1, high exactly 1 cycle per handshake;
  - response: `mac_valid_i` in cycle M gives `rsp_valid_o` in cycle M+1.
- Throughput:
  - 1 grant per cycle while credits remain;
  - MAX_OUTSTANDING=1 alternates grant/wait around the MAC latency.
- Outputs while `mac_valid_o = 0`: `mac_*_o` data holds its last value, with no functional meaning.

## Configuration
- `GARUDA_MAC_ARB_PERF_EN` defined:
  - 32-bit per-requester grant counters, incrementing on each handshake and wrapping at 2^32;
  - cleared by reset;
  - `perf_cnt_o` = counter[`perf_sel_i`], combinational;
  - a select ≥ NUM_REQ returns 0.
- Not defined: counters are absent and `perf_cnt_o` is tied to 0.

## Test plan
- **Single request:** reset, then requester 0 sends MAC8_ACC rs1=5, rs2=3, rd=10.
  - `mac_valid_o` next cycle with hartid 0, id 0.
  - `rsp_valid_o = 4'b0001` with result 25 one cycle after the MAC returns.
- **Round robin:** all four requesters hold valid, MAX_OUTSTANDING=8.
  - Grants 0,1,2,3,0 on consecutive cycles.
  - `mac_id_o` 0,1,2,3,4.
- **Credit limit:** MAX_OUTSTANDING=2, requester 1 continuously valid, MAC return delayed.
  - Exactly 2 grants, then `req_ready_o = 0` until `mac_valid_i`.
  - Grant resumes the cycle after the return.
- **Tag wrap:** 9 sequential single transactions.
  - Ninth carries id 0.
  - `err_o` stays 0.
- **Protocol error:** inject `mac_valid_i` with id 5 while idle.
  - `err_o` is 1 from the next cycle, no `rsp_valid_o`.
  - Cleared only by `rst_i`.
- **Perf counters** (`GARUDA_MAC_ARB_PERF_EN`): 3 grants to requester 2.
  - `perf_sel_i = 2` reads 3.
  - `perf_sel_i = 0` reads 0.
  - Mid-stream `rst_i` zeroes both.

Source files
------------

// File: rtl/garuda_mac_arbiter.sv
// garuda_mac_arbiter: round-robin front end that shares one int8_mac_unit
// among NUM_REQ requesters. Issue is credit-limited to MAX_OUTSTANDING
// operations, every issue carries a 3-bit tag, and a tag scoreboard checks
// each returning result before it is routed back to its requester.
// Optional build macro: GARUDA_MAC_ARB_PERF_EN adds per-requester grant
// counters readable through perf_sel_i / perf_cnt_o.
module garuda_mac_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int XLEN            = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  logic [NUM_REQ*XLEN-1:0] req_rs1_i,
  input  logic [NUM_REQ*XLEN-1:0] req_rs2_i,
  input  logic [NUM_REQ*XLEN-1:0] req_rd_i,
  input  logic [NUM_REQ*4-1:0]    req_opcode_i,
  input  logic [NUM_REQ*5-1:0]    req_rd_addr_i,
  output logic                    mac_valid_o,
  output logic [XLEN-1:0]         mac_rs1_o,
  output logic [XLEN-1:0]         mac_rs2_o,
  output logic [XLEN-1:0]         mac_rd_o,
  output logic [3:0]              mac_opcode_o,
  output logic [4:0]              mac_rd_addr_o,
  output logic [1:0]              mac_hartid_o,
  output logic [2:0]              mac_id_o,
  input  logic                    mac_valid_i,
  input  logic                    mac_we_i,
  input  logic [XLEN-1:0]         mac_result_i,
  input  logic [4:0]              mac_rd_addr_i,
  input  logic [1:0]              mac_hartid_i,
  input  logic [2:0]              mac_id_i,
  output logic [NUM_REQ-1:0]      rsp_valid_o,
  output logic                    rsp_we_o,
  output logic [XLEN-1:0]         rsp_result_o,
  output logic [4:0]              rsp_rd_addr_o,
  output logic                    err_o,
  input  logic [1:0]              perf_sel_i,
  output logic [31:0]             perf_cnt_o
);

  logic [1:0] ptr_reg, ptr_next;
  logic [2:0] tag_reg, tag_next;
  logic [3:0] outstanding_reg, outstanding_next;
  logic [7:0] busy_reg, busy_next;
  logic [1:0] owner_reg [8];
  logic       err_reg;

  logic [XLEN-1:0] rs1_arr    [NUM_REQ];
  logic [XLEN-1:0] rs2_arr    [NUM_REQ];
  logic [XLEN-1:0] rd_arr     [NUM_REQ];
  logic [3:0]      opcode_arr [NUM_REQ];
  logic [4:0]      rd_addr_arr[NUM_REQ];

  logic       grant_any;
  logic [1:0] grant_idx;
  logic [2:0] scan_idx;
  logic [2:0] ptr_inc;
  logic       credit_ok;
  logic       handshake;
  logic       ret_bad;
  logic       ret_ok;

  genvar gi;

  // Unpack the per-requester operand slices
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign rs1_arr[gi]     = req_rs1_i[gi*XLEN +: XLEN];
      assign rs2_arr[gi]     = req_rs2_i[gi*XLEN +: XLEN];
      assign rd_arr[gi]      = req_rd_i[gi*XLEN +: XLEN];
      assign opcode_arr[gi]  = req_opcode_i[gi*4 +: 4];
      assign rd_addr_arr[gi] = req_rd_addr_i[gi*5 +: 5];
    end
  endgenerate

  // Rotating-priority search: scan from the farthest candidate back to the
  // pointer so the nearest valid index at/after the pointer wins
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_idx = {1'b0, ptr_reg} + 3'(k);
      if (scan_idx >= 3'(NUM_REQ)) begin
        scan_idx = scan_idx - 3'(NUM_REQ);
      end
      if (req_valid_i[scan_idx[1:0]]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx[1:0];
      end
    end
  end

  // A same-cycle return does not free a credit: only registered count matters
  assign credit_ok = (outstanding_reg < 4'(MAX_OUTSTANDING));
  assign handshake = grant_any && credit_ok && !rst_i;

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready_o[gi] = handshake && (grant_idx == 2'(gi));
    end
  endgenerate

  // Return-path scoreboard check: tag must be live, owned by the claimed
  // requester, and the requester index must exist
  assign ret_bad = mac_valid_i &&
                   (!busy_reg[mac_id_i] ||
                    (owner_reg[mac_id_i] != mac_hartid_i) ||
                    ({1'b0, mac_hartid_i} >= 3'(NUM_REQ)));
  assign ret_ok  = mac_valid_i && !ret_bad;

  assign ptr_inc = {1'b0, grant_idx} + 3'd1;

  // Next-state for pointer, tag, credit count and scoreboard
  always_comb begin
    ptr_next         = ptr_reg;
    tag_next         = tag_reg;
    outstanding_next = outstanding_reg;
    busy_next        = busy_reg;
    if (handshake) begin
      ptr_next = (ptr_inc >= 3'(NUM_REQ)) ? 2'd0 : ptr_inc[1:0];
      tag_next = tag_reg + 3'd1;
    end
    if (handshake && !ret_ok) begin
      outstanding_next = outstanding_reg + 4'd1;
    end else if (!handshake && ret_ok) begin
      outstanding_next = outstanding_reg - 4'd1;
    end
    if (ret_ok) begin
      busy_next[mac_id_i] = 1'b0;
    end
    if (handshake) begin
      busy_next[tag_reg] = 1'b1;
    end
  end

  // Arbiter state, issue registers and response registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_reg         <= '0;
      tag_reg         <= '0;
      outstanding_reg <= '0;
      busy_reg        <= '0;
      err_reg         <= 1'b0;
      for (int t = 0; t < 8; t++) begin
        owner_reg[t] <= '0;
      end
      mac_valid_o   <= 1'b0;
      mac_rs1_o     <= '0;
      mac_rs2_o     <= '0;
      mac_rd_o      <= '0;
      mac_opcode_o  <= '0;
      mac_rd_addr_o <= '0;
      mac_hartid_o  <= '0;
      mac_id_o      <= '0;
      rsp_valid_o   <= '0;
      rsp_we_o      <= 1'b0;
      rsp_result_o  <= '0;
      rsp_rd_addr_o <= '0;
    end else begin
      ptr_reg         <= ptr_next;
      tag_reg         <= tag_next;
      outstanding_reg <= outstanding_next;
      busy_reg        <= busy_next;
      err_reg         <= err_reg | ret_bad;
      mac_valid_o     <= handshake;
      if (handshake) begin
        owner_reg[tag_reg] <= grant_idx;
        mac_rs1_o          <= rs1_arr[grant_idx];
        mac_rs2_o          <= rs2_arr[grant_idx];
        mac_rd_o           <= rd_arr[grant_idx];
        mac_opcode_o       <= opcode_arr[grant_idx];
        mac_rd_addr_o      <= rd_addr_arr[grant_idx];
        mac_hartid_o       <= grant_idx;
        mac_id_o           <= tag_reg;
      end
      for (int k = 0; k < NUM_REQ; k++) begin
        rsp_valid_o[k] <= ret_ok && (mac_hartid_i == 2'(k));
      end
      if (ret_ok) begin
        rsp_we_o      <= mac_we_i;
        rsp_result_o  <= mac_result_i;
        rsp_rd_addr_o <= mac_rd_addr_i;
      end
    end
  end

  assign err_o = err_reg;

`ifdef GARUDA_MAC_ARB_PERF_EN
  logic [31:0] perf_arr [4];

  // One wrapping grant counter per requester; unused select slots read 0
  generate
    for (gi = 0; gi < 4; gi++) begin : g_perf
      if (gi < NUM_REQ) begin : g_cnt
        logic [31:0] cnt_reg;
        always_ff @(posedge clk_i or posedge rst_i) begin
          if (rst_i) begin
            cnt_reg <= '0;
          end else if (req_ready_o[gi]) begin
            cnt_reg <= cnt_reg + 32'd1;
          end
        end
        assign perf_arr[gi] = cnt_reg;
      end else begin : g_zero
        assign perf_arr[gi] = '0;
      end
    end
  endgenerate

  assign perf_cnt_o = perf_arr[perf_sel_i];
`else
  logic unused_perf_sel;
  assign unused_perf_sel = ^perf_sel_i;
  assign perf_cnt_o      = '0;
`endif

endmodule
